// File: rtl/lcd_fmt_pkg.sv
// Shared definitions for the LCD field formatter: sequencer state encoding,
// double-dabble sizing and the ASCII codes written to the character buffer.
package lcd_fmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

  localparam int BCD_DIGITS  = 20;  // enough decimal digits for any 64-bit value
  localparam int CONV_CYCLES = 64;  // one dabble step per input bit

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_OVF   = 8'h23;

  // Pre-shift correction: a digit >= 5 would become >= 10 after doubling,
  // so add 3 to push the carry into the next digit. Max 9+3 = 12, no carry out.
  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Serial 64-bit binary to 20-digit BCD converter (shift-and-add-3).
// Ports:
//   clk, rst      clock, async active-high reset
//   load_i        capture load_value_i and clear the BCD accumulator
//   load_value_i  64-bit unsigned input value
//   step_i        perform one adjust-and-shift iteration
//   bcd_o         20 packed BCD digits, digit 0 in bits [3:0]
//   done_o        high during the step that completes the 64th iteration
module bcd_dabble_core
  import lcd_fmt_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [63:0]               load_value_i,
  input  logic                      step_i,
  output logic [BCD_DIGITS*4-1:0]   bcd_o,
  output logic                      done_o
);

  logic [63:0]             bin_q, bin_d;
  logic [BCD_DIGITS*4-1:0] bcd_q, bcd_d;
  logic [BCD_DIGITS*4-1:0] adj;
  logic [6:0]              cnt_q, cnt_d;

  always_comb begin
    adj = '0;
    for (int j = 0; j < BCD_DIGITS; j++) adj[j*4 +: 4] = dabble_adj(bcd_q[j*4 +: 4]);
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load_i) begin
      bin_d = load_value_i;
      bcd_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o  = bcd_q;
  // Flags the final iteration so the caller can leave its convert state on
  // the same edge that lands the last shift.
  assign done_o = step_i && (cnt_q == 7'(CONV_CYCLES - 1));

endmodule

// File: rtl/lcd_field_writer.sv
// Formats a 64-bit unsigned value as N_DIGITS ASCII characters and writes them
// most-significant first into an LCD character buffer.
// Ports:
//   CLK_50MHZ, RST   clock, async active-high reset
//   START, VALUE     request handshake, sampled only while idle
//   BUSY, DONE       busy from accept through the DONE cycle; one-cycle DONE
//   OVERFLOW         value needed more than N_DIGITS digits (held until next accept)
//   WR_EN/ADDR/DATA  character write beats, address/data hold when WR_EN=0
module lcd_field_writer
  import lcd_fmt_pkg::*;
#(
  parameter int N_DIGITS      = 14,
  parameter int BASE_ADDR     = 0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        CLK_50MHZ,
  input  logic        RST,
  input  logic        START,
  input  logic [63:0] VALUE,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERFLOW,
  output logic        WR_EN,
  output logic [7:0]  WR_ADDR,
  output logic [7:0]  WR_DATA
);

  state_e                          state_q, state_d;
  logic                            load, step, core_done;
  logic [BCD_DIGITS*4-1:0]         bcd;
  logic [BCD_DIGITS-1:0][3:0]      digits;
  logic [4:0]                      beat_q, beat_d;
  logic                            seen_nz_q, seen_nz_d;
  logic                            ovf_q, ovf_d;
  logic                            wr_en_q, wr_en_d;
  logic [7:0]                      wr_addr_q, wr_addr_d;
  logic [7:0]                      wr_data_q, wr_data_d;
  logic                            ovf_now;
  logic [4:0]                      dig_idx;
  logic [3:0]                      cur_digit;

  bcd_dabble_core u_core (
    .clk          (CLK_50MHZ),
    .rst          (RST),
    .load_i       (load),
    .load_value_i (VALUE),
    .step_i       (step),
    .bcd_o        (bcd),
    .done_o       (core_done)
  );

  assign digits = bcd;

  // State register
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (START) state_d = ST_CONVERT;
      ST_CONVERT: if (core_done) state_d = ST_EMIT;
      ST_EMIT:    if (beat_q == 5'(N_DIGITS)) state_d = ST_FINISH;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    load = (state_q == ST_IDLE) && START;
    step = (state_q == ST_CONVERT);
    BUSY = (state_q != ST_IDLE);
    DONE = (state_q == ST_FINISH);
  end

  // Emit datapath. The BCD register is frozen during EMIT, so overflow and the
  // current digit can be decoded straight from it on every beat.
  always_comb begin
    ovf_now = 1'b0;
    for (int j = 0; j < BCD_DIGITS; j++)
      if (j >= N_DIGITS && digits[j] != 4'd0) ovf_now = 1'b1;

    dig_idx   = (beat_q < 5'(N_DIGITS)) ? 5'(N_DIGITS - 1) - beat_q : 5'd0;
    cur_digit = digits[dig_idx];

    beat_d    = beat_q;
    seen_nz_d = seen_nz_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (load) begin
      beat_d    = '0;
      seen_nz_d = 1'b0;
      ovf_d     = 1'b0;
    end

    if (state_q == ST_EMIT && beat_q < 5'(N_DIGITS)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = 8'(BASE_ADDR) + {3'b000, beat_q};
      beat_d    = beat_q + 5'd1;
      if (beat_q == 5'd0) ovf_d = ovf_now;
      if (cur_digit != 4'd0) seen_nz_d = 1'b1;
      // The final beat is never blanked so a zero value still shows '0'.
      if (ovf_now)
        wr_data_d = ASCII_OVF;
      else if (BLANK_LEADING && cur_digit == 4'd0 && !seen_nz_q &&
               beat_q != 5'(N_DIGITS - 1))
        wr_data_d = ASCII_SPACE;
      else
        wr_data_d = ASCII_ZERO + {4'd0, cur_digit};
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      beat_q    <= '0;
      seen_nz_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      beat_q    <= beat_d;
      seen_nz_q <= seen_nz_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign OVERFLOW = ovf_q;
  assign WR_EN    = wr_en_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_lcd_field_writer.sv
module tb_lcd_field_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [63:0] value_a = '0, value_b = '0;
  logic        busy_a, done_a, ovf_a, wr_en_a;
  logic        busy_b, done_b, ovf_b, wr_en_b;
  logic [7:0]  addr_a, data_a, addr_b, data_b;

  localparam int NA = 14, BASEA = 16;
  localparam int NB = 20, BASEB = 0;

  lcd_field_writer #(.N_DIGITS(NA), .BASE_ADDR(BASEA), .BLANK_LEADING(1'b1)) dut_a (
    .CLK_50MHZ(clk), .RST(rst), .START(start_a), .VALUE(value_a),
    .BUSY(busy_a), .DONE(done_a), .OVERFLOW(ovf_a),
    .WR_EN(wr_en_a), .WR_ADDR(addr_a), .WR_DATA(data_a));

  lcd_field_writer #(.N_DIGITS(NB), .BASE_ADDR(BASEB), .BLANK_LEADING(1'b0)) dut_b (
    .CLK_50MHZ(clk), .RST(rst), .START(start_b), .VALUE(value_b),
    .BUSY(busy_b), .DONE(done_b), .OVERFLOW(ovf_b),
    .WR_EN(wr_en_b), .WR_ADDR(addr_b), .WR_DATA(data_b));

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_beats_a[$], exp_beats_b[$];
  logic        exp_ovf_a[$],   exp_ovf_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: print the value in decimal, then right-justify it in n columns.
  task automatic model(input logic [63:0] v, input int n, input bit blank,
                       output logic [159:0] chars, output bit ovf);
    string s;
    s     = $sformatf("%0d", v);
    ovf   = (s.len() > n);
    chars = '0;
    for (int i = 0; i < n; i++) begin
      int  p;
      byte c;
      p = i - (n - s.len());
      if (ovf)        c = 8'h23;
      else if (p < 0) c = blank ? 8'h20 : 8'h30;
      else            c = s[p];
      chars[i*8 +: 8] = c;
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_a === 1'b1) begin
        if (exp_beats_a.size() == 0) chk("a_unexpected_wr", wr_en_a, 0);
        else begin
          logic [15:0] e;
          e = exp_beats_a.pop_front();
          chk("a_wr_addr", addr_a, e[15:8]);
          chk("a_wr_data", data_a, e[7:0]);
        end
      end
      if (done_a === 1'b1) begin
        if (exp_ovf_a.size() == 0) chk("a_unexpected_done", done_a, 0);
        else begin
          chk("a_overflow", ovf_a, exp_ovf_a.pop_front());
          chk("a_beats_left_at_done", exp_beats_a.size(), 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_b === 1'b1) begin
        if (exp_beats_b.size() == 0) chk("b_unexpected_wr", wr_en_b, 0);
        else begin
          logic [15:0] e;
          e = exp_beats_b.pop_front();
          chk("b_wr_addr", addr_b, e[15:8]);
          chk("b_wr_data", data_b, e[7:0]);
        end
      end
      if (done_b === 1'b1) begin
        if (exp_ovf_b.size() == 0) chk("b_unexpected_done", done_b, 0);
        else begin
          chk("b_overflow", ovf_b, exp_ovf_b.pop_front());
          chk("b_beats_left_at_done", exp_beats_b.size(), 0);
        end
      end
    end
  end

  // mode 0: plain request; 1: extra START pulses during CONVERT and EMIT;
  // 2: reset during beat 5 of EMIT. Called at a negedge with DUT idle.
  task automatic run_a(input logic [63:0] v, input int mode);
    logic [159:0] ch;
    bit           o;
    int           cyc, first;
    model(v, NA, 1'b1, ch, o);
    for (int i = 0; i < NA; i++) exp_beats_a.push_back({8'(BASEA + i), ch[i*8 +: 8]});
    exp_ovf_a.push_back(o);
    start_a = 1'b1;
    value_a = v;
    @(posedge clk);
    #1 chk("a_busy_on_accept", busy_a, 1);
    @(negedge clk);
    start_a = 1'b0;
    value_a = {$urandom(), $urandom()};
    cyc   = 0;
    first = -1;
    while (busy_a && cyc < 200) begin
      if (wr_en_a && first < 0) first = cyc;
      start_a = (mode == 1 && (cyc == 10 || cyc == 70));
      if (mode == 2 && cyc == 70) begin
        #2 rst = 1'b1;
        #1;
        chk("a_rst_wr_en", wr_en_a, 0);
        chk("a_rst_busy", busy_a, 0);
        chk("a_rst_done", done_a, 0);
        chk("a_rst_ovf", ovf_a, 0);
        chk("a_rst_addr", addr_a, 0);
        exp_beats_a.delete();
        exp_ovf_a.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      cyc++;
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("a_busy_cycles", cyc, NA + 66);
    chk("a_first_wr_cycle", first, 65);
    chk("a_ovf_hold", ovf_a, o);
  endtask

  task automatic run_b(input logic [63:0] v);
    logic [159:0] ch;
    bit           o;
    int           cyc, first;
    model(v, NB, 1'b0, ch, o);
    for (int i = 0; i < NB; i++) exp_beats_b.push_back({8'(BASEB + i), ch[i*8 +: 8]});
    exp_ovf_b.push_back(o);
    start_b = 1'b1;
    value_b = v;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    value_b = {$urandom(), $urandom()};
    cyc   = 0;
    first = -1;
    while (busy_b && cyc < 200) begin
      if (wr_en_b && first < 0) first = cyc;
      cyc++;
      @(negedge clk);
    end
    chk("b_busy_cycles", cyc, NB + 66);
    chk("b_first_wr_cycle", first, 65);
    chk("b_ovf_hold", ovf_b, o);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_wr_en_a", wr_en_a, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_ovf_b", ovf_b, 0);
    chk("rst_addr_b", addr_b, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_a(64'd0, 0);
    run_b(64'd0);
    run_a(64'd44720, 0);
    run_a(64'd100000000000000, 0);
    run_a(64'd5, 0);
    run_a(64'd99999999999999, 0);
    run_b(64'hFFFF_FFFF_FFFF_FFFF);
    run_b(64'd7);
    run_a(64'd123456, 1);
    run_a(64'd987654321, 2);
    run_a(64'd123, 0);
    for (int i = 0; i < 10; i++) begin
      logic [63:0] v;
      v = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      run_a(v, 0);
      v = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      run_b(v);
    end

    repeat (4) @(negedge clk);
    chk("a_queue_drained", exp_beats_a.size() + exp_ovf_a.size(), 0);
    chk("b_queue_drained", exp_beats_b.size() + exp_ovf_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
